perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event counters for core performance monitoring. It generalises the fixed cycle, miss, access and prediction counters to `NUM_CH` channels of width `CNT_W`. Each channel has a multi-event increment, per-channel stall gating, sticky overflow, atomic snapshot shadows, and an auto-sampling window. It sits beside the pipeline, is fed by pipeline and cache event strobes, and is read by the verification environment and by the debug/CP15-style readout path.

## Interface
- `NUM_CH`, 8: number of counter channels (1..32).
- `CNT_W`, 32: counter and shadow width in bits (8..64).
- `INC_W`, 2: per-channel increment width; max increment per cycle is 2^INC_W-1.
- `WIN_W`, 16: width of the sampling-window length.
- `nGCLK` in 1: core clock; all state updates on the rising edge.
- `nRESET` in 1: asynchronous, active-low reset.
- `nWAIT` in 1: core clock-enable; low means memory stall.
- `inc` in NUM_CH*INC_W: per-channel increment; channel k occupies bits [k*INC_W +: INC_W].
- `gate_mode` in NUM_CH: 1 means channel k counts only while `nWAIT`=1; 0 means it counts every cycle.
- `cmd` in 2: 00 NOP, 01 START, 10 STOP, 11 CLEAR.
- `snap` in 1: copy all live counters into shadows.
- `win_len` in WIN_W: auto-sample window in cycles; 0 disables windowing.
- `ovf_clr` in NUM_CH: W1C mask for the sticky overflow bits.
- `rd_sel` in $clog2(NUM_CH): channel to read.
- `rd_shadow` in 1: 1 reads the shadow register, 0 reads the live counter.
- `rd_data` out CNT_W: registered read data.
- `ovf` out NUM_CH: sticky overflow flags.
- `running` out 1: FSM is in RUN.
- `win_done` out 1: one-cycle pulse when a window expires.
- `irq` out 1: OR-reduction of `ovf` and `win_done`.

## Operation
- FSM has two states, STOPPED and RUN. Reset enters STOPPED.
  - STOPPED→RUN on START.
  - RUN→STOPPED on STOP.
  - CLEAR does not change state.
- Counting, in RUN only: `cnt[k] <= cnt[k] + inc[k]` when `gate_mode[k]`=0 or `nWAIT`=1.
  - `inc[k]` is zero-extended to CNT_W.
  - The sum wraps modulo 2^CNT_W.
- Overflow: if the CNT_W+1-bit sum carries out, set `ovf[k]`. The flag is sticky until cleared through `ovf_clr[k]`.
  - If a carry and `ovf_clr[k]` occur in the same cycle, the set wins.
- CLEAR: zeroes all live counters and the window counter.
  - Does not clear shadows or `ovf`.
  - Any increment in the same cycle is dropped; the counter is 0 next cycle.
- Snapshot: `shadow[k] <= cnt[k]`, the value before this edge's update, for all k in the same edge.
  - If snap and CLEAR occur together, the shadow receives the pre-clear value and the live counter becomes 0. This is interval sampling with no lost events.
  - Snapshot is legal in STOPPED.
- Window, active when RUN and `win_len`≠0:
  - `win_cnt` increments every cycle, with no `nWAIT` gating.
  - When `win_cnt == win_len-1`: perform snapshot + clear of all live counters, reset `win_cnt` to 0, and pulse `win_done` the next cycle.
  - `win_cnt` holds in STOPPED.
  - Changing `win_len` takes effect on the next compare. If `win_cnt` ≥ the new `win_len`, the compare fails and `win_cnt` counts until it wraps.
- An explicit CLEAR in the same cycle as window expiry still produces exactly one snapshot and one `win_done` pulse.
- Read: `rd_data <= rd_shadow ? shadow[rd_sel] : cnt[rd_sel]`, registered.
  - An `rd_sel` ≥ NUM_CH returns 0.

## Timing
- Reset values: all counters, shadows, `win_cnt`, `ovf`, `rd_data`, `win_done` and `irq` are 0, and the FSM is STOPPED. Reset is asynchronous and takes effect immediately, even mid-window or mid-count.
- Increment latency: an event at edge N is visible in the live counter after edge N, and in `rd_data` after edge N+1.
- START at edge N: events sampled at edge N+1 onward are counted; events at edge N are not.
- STOP at edge N: events at edge N are still counted.
- `ovf` is visible the cycle after the wrapping edge. `irq` is combinational from the `ovf` and `win_done` registers.
- `win_done` is high for exactly one cycle, the cycle after expiry; `shadow` is valid in that same cycle.

## Structure
- Package `perf_pkg` holds:
  - the cmd encodings (`PERF_NOP`, `PERF_START`, `PERF_STOP`, `PERF_CLEAR`);
  - the FSM state enum;
  - default parameter constants.
- Sub-module `perf_ctr_ch`: one channel, containing live counter, shadow, sticky ovf, gate and clear logic. It is instantiated NUM_CH times by a generate loop.
- The top level holds the FSM, the window counter, and the read mux/register.

## Test plan
- Reset, START, then `inc[0]`=3 for 4 cycles with `nWAIT`=1 → `cnt[0]`=12. A read with `rd_sel`=0 returns 12 one cycle later. `running`=1.
- `gate_mode[1]`=1 and `gate_mode[2]`=0, both `inc`=1, for 10 cycles with `nWAIT` low on 4 of them → `cnt[1]`=6, `cnt[2]`=10.
- CNT_W=8: preload to 254 via counting, then `inc`=3 → `cnt`=1 and `ovf` set with `irq`=1. `ovf_clr` asserted in the same cycle as a second wrap → `ovf` stays 1.
- `snap` and CLEAR in the same cycle with `cnt[0]`=57 and `inc[0]`=2 → `shadow[0]`=57 and `cnt[0]`=0 next cycle.
- `win_len`=5, `inc`=1 constantly → `win_done` pulses every 5 cycles, `shadow`=5 each window, and no events are lost across windows.
- `nRESET` asserted mid-window while running → all outputs are 0 asynchronously, the FSM is STOPPED, and counting stays halted after release until START.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: command encodings,
// controller states and default sizing.
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_NOP   = 2'b00,
    PERF_START = 2'b01,
    PERF_STOP  = 2'b10,
    PERF_CLEAR = 2'b11
  } perf_cmd_e;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } perf_state_e;

  localparam int PERF_NUM_CH_DEF = 8;
  localparam int PERF_CNT_W_DEF  = 32;
  localparam int PERF_INC_W_DEF  = 2;
  localparam int PERF_WIN_W_DEF  = 16;

  // A single-channel bank still needs a one-bit read select.
  function automatic int perf_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_ctr_ch.sv
// One counter channel: live counter, snapshot shadow and sticky overflow flag.
module perf_ctr_ch
  import perf_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W_DEF,
  parameter int INC_W = PERF_INC_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             count_en_i,
  input  logic [INC_W-1:0] inc_i,
  input  logic             clear_i,
  input  logic             snap_i,
  input  logic             win_exp_i,
  input  logic             ovf_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;
  logic [INC_W-1:0] inc_eff;
  logic [CNT_W:0]   sum;

  assign inc_eff = count_en_i ? inc_i : '0;
  assign sum     = {1'b0, cnt_q} + (CNT_W+1)'(inc_eff);

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q & ~ovf_clr_i;
    if (win_exp_i) begin
      // Window expiry keeps this edge's events in the closing window, so
      // consecutive windows partition the event stream with nothing lost.
      shadow_d = sum[CNT_W-1:0];
      cnt_d    = '0;
      ovf_d    = ovf_d | sum[CNT_W];
    end else begin
      if (snap_i) shadow_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = sum[CNT_W-1:0];
        ovf_d = ovf_d | sum[CNT_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters with run/stop control, auto-sampling window
// and a registered read port.
//   state      | meaning
//   ST_STOPPED | counters and window hold; snapshot and clear still act
//   ST_RUN     | channels count enabled events; window advances
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = PERF_NUM_CH_DEF,
  parameter int CNT_W  = PERF_CNT_W_DEF,
  parameter int INC_W  = PERF_INC_W_DEF,
  parameter int WIN_W  = PERF_WIN_W_DEF,
  localparam int SEL_W = perf_sel_w(NUM_CH)
) (
  input  logic                    nGCLK,
  input  logic                    nRESET,
  input  logic                    nWAIT,
  input  logic [NUM_CH*INC_W-1:0] inc,
  input  logic [NUM_CH-1:0]       gate_mode,
  input  logic [1:0]              cmd,
  input  logic                    snap,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [NUM_CH-1:0]       ovf_clr,
  input  logic [SEL_W-1:0]        rd_sel,
  input  logic                    rd_shadow,
  output logic [CNT_W-1:0]        rd_data,
  output logic [NUM_CH-1:0]       ovf,
  output logic                    running,
  output logic                    win_done,
  output logic                    irq
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  perf_state_e      state_q;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic             win_done_q;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             run;
  logic             clear_cmd;
  logic             win_active;
  logic             win_exp;
  logic [CNT_W-1:0] cnt_w    [NUM_CH];
  logic [CNT_W-1:0] shadow_w [NUM_CH];

  assign run        = (state_q == ST_RUN);
  assign clear_cmd  = (cmd == PERF_CLEAR);
  assign win_active = run && (win_len != '0);
  // Shrinking win_len below win_cnt misses the compare until win_cnt wraps.
  assign win_exp    = win_active && (win_cnt_q == win_len - WIN_W'(1));

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_STOPPED;
    end else begin
      case (perf_cmd_e'(cmd))
        PERF_START: state_q <= ST_RUN;
        PERF_STOP:  state_q <= ST_STOPPED;
        default:    state_q <= state_q;
      endcase
    end
  end

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (clear_cmd || win_exp) win_cnt_d = '0;
    else if (win_active)      win_cnt_d = win_cnt_q + WIN_W'(1);
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      win_cnt_q  <= '0;
      win_done_q <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      win_done_q <= win_exp;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    perf_ctr_ch #(
      .CNT_W(CNT_W),
      .INC_W(INC_W)
    ) u_ch (
      .clk_i     (nGCLK),
      .rst_n_i   (nRESET),
      .count_en_i(run && (!gate_mode[k] || nWAIT)),
      .inc_i     (inc[k*INC_W +: INC_W]),
      .clear_i   (clear_cmd),
      .snap_i    (snap),
      .win_exp_i (win_exp),
      .ovf_clr_i (ovf_clr[k]),
      .cnt_o     (cnt_w[k]),
      .shadow_o  (shadow_w[k]),
      .ovf_o     (ovf[k])
    );
  end

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_sel} < NUM_CH_L) begin
      rd_data_d = rd_shadow ? shadow_w[rd_sel] : cnt_w[rd_sel];
    end
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data  = rd_data_q;
  assign running  = run;
  assign win_done = win_done_q;
  assign irq      = (|ovf) | win_done_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed vector table, hand-written corner
// sequences and a randomized run against an arithmetic reference model.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int IW  = 2;
  localparam int WW  = 8;
  localparam int MOD = 256;

  logic              nGCLK = 1'b0;
  logic              nRESET = 1'b0;
  logic              nWAIT = 1'b1;
  logic [NCH*IW-1:0] inc = '0;
  logic [NCH-1:0]    gate_mode = '0;
  logic [1:0]        cmd = 2'b00;
  logic              snap = 1'b0;
  logic [WW-1:0]     win_len = '0;
  logic [NCH-1:0]    ovf_clr = '0;
  logic [2:0]        rd_sel = '0;
  logic              rd_shadow = 1'b0;
  logic [CW-1:0]     rd_data;
  logic [NCH-1:0]    ovf;
  logic              running, win_done, irq;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .WIN_W(WW)) dut (
    .nGCLK(nGCLK), .nRESET(nRESET), .nWAIT(nWAIT), .inc(inc),
    .gate_mode(gate_mode), .cmd(cmd), .snap(snap), .win_len(win_len),
    .ovf_clr(ovf_clr), .rd_sel(rd_sel), .rd_shadow(rd_shadow),
    .rd_data(rd_data), .ovf(ovf), .running(running), .win_done(win_done),
    .irq(irq)
  );

  always #5 nGCLK = ~nGCLK;

  int errors = 0;
  int checks = 0;

  // Reference model state, kept as plain integers.
  int m_cnt [NCH];
  int m_sh  [NCH];
  bit [NCH-1:0] m_ovf;
  bit m_run, m_wd;
  int m_win, m_rd;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = 0;
      m_sh[k]  = 0;
    end
    m_ovf = '0; m_run = 0; m_wd = 0; m_win = 0; m_rd = 0;
  endfunction

  function automatic void model_update();
    int  rd_new, wl, amt, total;
    bit  expire, clr, en, carry, nv;
    wl     = int'(win_len);
    clr    = (cmd == 2'b11);
    expire = m_run && (wl != 0) && (m_win == wl - 1);
    rd_new = 0;
    if (int'(rd_sel) < NCH) rd_new = rd_shadow ? m_sh[rd_sel] : m_cnt[rd_sel];
    for (int k = 0; k < NCH; k++) begin
      amt   = (int'(inc) >> (IW * k)) & 3;
      en    = m_run && (!gate_mode[k] || nWAIT);
      total = m_cnt[k] + (en ? amt : 0);
      carry = (total >= MOD);
      nv    = m_ovf[k] && !ovf_clr[k];
      if (expire) begin
        m_sh[k]  = total % MOD;
        m_cnt[k] = 0;
        nv       = nv || carry;
      end else begin
        if (snap) m_sh[k] = m_cnt[k];
        if (clr) m_cnt[k] = 0;
        else begin
          m_cnt[k] = total % MOD;
          nv       = nv || carry;
        end
      end
      m_ovf[k] = nv;
    end
    if (clr || expire)           m_win = 0;
    else if (m_run && wl != 0)   m_win = (m_win + 1) % MOD;
    m_wd = expire;
    m_rd = rd_new;
    if (cmd == 2'b01)      m_run = 1;
    else if (cmd == 2'b10) m_run = 0;
  endfunction

  task automatic model_check();
    chk("m_rd_data", rd_data, m_rd);
    chk("m_ovf", ovf, m_ovf);
    chk("m_running", running, m_run);
    chk("m_win_done", win_done, m_wd);
    chk("m_irq", irq, (|m_ovf) | m_wd);
  endtask

  task automatic cycle();
    @(posedge nGCLK);
    model_update();
    #1;
    model_check();
  endtask

  task automatic drive(input logic [1:0] c, input logic [11:0] i, input logic s,
                       input logic [2:0] sel, input logic sh);
    cmd = c; inc = i; snap = s; rd_sel = sel; rd_shadow = sh;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [11:0] inc;
    logic        snap;
    logic [2:0]  sel;
    logic        sh;
    int          exp_rd;
    logic        exp_run;
  } vec_t;

  vec_t tbl [21];
  int   pulses;
  bit   prev_pulse;

  initial begin
    tbl[0]  = '{2'd1, 12'h003, 1'b0, 3'd0, 1'b0, 0,  1'b1};
    tbl[1]  = '{2'd0, 12'h003, 1'b0, 3'd0, 1'b0, 0,  1'b1};
    tbl[2]  = '{2'd0, 12'h003, 1'b0, 3'd0, 1'b0, 3,  1'b1};
    tbl[3]  = '{2'd0, 12'h003, 1'b0, 3'd0, 1'b0, 6,  1'b1};
    tbl[4]  = '{2'd0, 12'h003, 1'b0, 3'd0, 1'b0, 9,  1'b1};
    tbl[5]  = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b0, 12, 1'b1};
    tbl[6]  = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b1, 0,  1'b1};
    tbl[7]  = '{2'd0, 12'h002, 1'b1, 3'd0, 1'b1, 0,  1'b1};
    tbl[8]  = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b1, 12, 1'b1};
    tbl[9]  = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b0, 14, 1'b1};
    tbl[10] = '{2'd3, 12'h003, 1'b0, 3'd0, 1'b0, 14, 1'b1};
    tbl[11] = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b0, 0,  1'b1};
    tbl[12] = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b1, 12, 1'b1};
    tbl[13] = '{2'd2, 12'h001, 1'b0, 3'd0, 1'b0, 0,  1'b0};
    tbl[14] = '{2'd0, 12'h003, 1'b0, 3'd0, 1'b0, 1,  1'b0};
    tbl[15] = '{2'd0, 12'h000, 1'b0, 3'd0, 1'b0, 1,  1'b0};
    tbl[16] = '{2'd0, 12'h000, 1'b0, 3'd7, 1'b0, 0,  1'b0};
    tbl[17] = '{2'd1, 12'h000, 1'b0, 3'd0, 1'b0, 1,  1'b1};
    tbl[18] = '{2'd0, 12'hC00, 1'b0, 3'd5, 1'b0, 0,  1'b1};
    tbl[19] = '{2'd0, 12'h000, 1'b0, 3'd5, 1'b0, 3,  1'b1};
    tbl[20] = '{2'd0, 12'h000, 1'b0, 3'd6, 1'b0, 0,  1'b1};

    // Reset state
    model_reset();
    #12;
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_running", running, 0);
    chk("rst_win_done", win_done, 0);
    chk("rst_irq", irq, 0);
    nRESET = 1'b1;

    // Directed vector table: start, counting, read latency, snapshot, clear, stop
    for (int r = 0; r < 21; r++) begin
      drive(tbl[r].cmd, tbl[r].inc, tbl[r].snap, tbl[r].sel, tbl[r].sh);
      cycle();
      chk($sformatf("tbl%0d_rd", r), rd_data, tbl[r].exp_rd);
      chk($sformatf("tbl%0d_run", r), running, tbl[r].exp_run);
    end

    // Stall gating: ch1 gated, ch2 free-running, nWAIT low on 4 of 10 cycles
    gate_mode = 6'b000010;
    drive(2'd3, 12'h000, 1'b0, 3'd0, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(2'd0, 12'h014, 1'b0, 3'd0, 1'b0);
      nWAIT = !(i % 2 == 1 && i < 8);
      cycle();
    end
    nWAIT = 1'b1;
    drive(2'd0, 12'h000, 1'b0, 3'd1, 1'b0);
    cycle();
    chk("gate_ch1", rd_data, 6);
    drive(2'd0, 12'h000, 1'b0, 3'd2, 1'b0);
    cycle();
    chk("gate_ch2", rd_data, 10);
    gate_mode = '0;

    // Overflow at 8 bits, then set-wins-over-clear on a second wrap
    drive(2'd3, 12'h000, 1'b0, 3'd0, 1'b0);
    cycle();
    for (int i = 0; i < 84; i++) begin drive(2'd0, 12'h003, 1'b0, 3'd0, 1'b0); cycle(); end
    drive(2'd0, 12'h002, 1'b0, 3'd0, 1'b0); cycle();
    chk("ovf_pre", ovf[0], 0);
    drive(2'd0, 12'h003, 1'b0, 3'd0, 1'b0); cycle();
    chk("ovf_set", ovf[0], 1);
    chk("ovf_irq", irq, 1);
    drive(2'd0, 12'h000, 1'b0, 3'd0, 1'b0); cycle();
    chk("ovf_wrap_val", rd_data, 1);
    for (int i = 0; i < 84; i++) begin drive(2'd0, 12'h003, 1'b0, 3'd0, 1'b0); cycle(); end
    drive(2'd0, 12'h002, 1'b0, 3'd0, 1'b0); cycle();
    drive(2'd0, 12'h001, 1'b0, 3'd0, 1'b0);
    ovf_clr = 6'b000001;
    cycle();
    chk("ovf_set_wins", ovf[0], 1);
    drive(2'd0, 12'h000, 1'b0, 3'd0, 1'b0);
    cycle();
    chk("ovf_cleared", ovf[0], 0);
    chk("ovf_irq_low", irq, 0);
    ovf_clr = '0;

    // Snapshot together with CLEAR
    drive(2'd3, 12'h000, 1'b0, 3'd0, 1'b0);
    cycle();
    for (int i = 0; i < 19; i++) begin drive(2'd0, 12'h003, 1'b0, 3'd0, 1'b0); cycle(); end
    drive(2'd3, 12'h002, 1'b1, 3'd0, 1'b0); cycle();
    chk("snapclr_prev_live", rd_data, 57);
    drive(2'd0, 12'h000, 1'b0, 3'd0, 1'b1); cycle();
    chk("snapclr_shadow", rd_data, 57);
    drive(2'd0, 12'h000, 1'b0, 3'd0, 1'b0); cycle();
    chk("snapclr_live", rd_data, 0);

    // Auto-sampling window of 5 with one event per cycle
    win_len = 8'd5;
    drive(2'd3, 12'h001, 1'b0, 3'd0, 1'b1);
    cycle();
    pulses = 0;
    prev_pulse = 0;
    for (int i = 0; i < 21; i++) begin
      drive(2'd0, 12'h001, 1'b0, 3'd0, 1'b1);
      cycle();
      if (prev_pulse) chk($sformatf("win_shadow_%0d", i), rd_data, 5);
      chk($sformatf("win_pulse_%0d", i), win_done, (i % 5 == 4));
      if (win_done) pulses++;
      prev_pulse = win_done;
    end
    chk("win_pulse_count", pulses, 4);

    // Asynchronous reset mid-window while running
    cycle();
    cycle();
    #2;
    nRESET = 1'b0;
    #1;
    chk("arst_rd_data", rd_data, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_running", running, 0);
    chk("arst_win_done", win_done, 0);
    chk("arst_irq", irq, 0);
    model_reset();
    #1;
    nRESET = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(2'd0, 12'h003, 1'b0, 3'd0, 1'b0); cycle(); end
    chk("arst_still_stopped", running, 0);
    drive(2'd0, 12'h000, 1'b0, 3'd0, 1'b0); cycle();
    chk("arst_no_count", rd_data, 0);
    drive(2'd1, 12'h003, 1'b0, 3'd0, 1'b0); cycle();
    drive(2'd0, 12'h003, 1'b0, 3'd0, 1'b0); cycle();
    drive(2'd0, 12'h000, 1'b0, 3'd0, 1'b0); cycle();
    chk("arst_restart", rd_data, 3);

    // Randomized run against the reference model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 19);
      cmd       = (r == 0) ? 2'd2 : (r == 1) ? 2'd3 : (r < 4) ? 2'd1 : 2'd0;
      inc       = 12'($urandom);
      gate_mode = 6'($urandom);
      nWAIT     = ($urandom_range(0, 3) != 0);
      snap      = ($urandom_range(0, 7) == 0);
      ovf_clr   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      rd_sel    = 3'($urandom);
      rd_shadow = 1'($urandom);
      if ($urandom_range(0, 63) == 0) win_len = 8'($urandom_range(0, 12));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
